// File: rtl/sw_host_pkg.sv
// Shared types and SW bus bit positions for the picoMips switch/LED host driver.
package sw_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    X_HI,
    X_LO,
    Y_HI,
    Y_LO,
    R_HI,
    R_LO,
    RES
  } state_t;

  localparam int SW_RUN_BIT = 9;
  localparam int SW_STB_BIT = 8;
  localparam int SW_DATA_W  = 8;

  function automatic logic phase_timed(input state_t s);
    return (s != IDLE) && (s != RES);
  endfunction

  // High phases drive SW8=1; every timed phase is either high or low.
  function automatic logic phase_hi(input state_t s);
    return (s == X_HI) || (s == Y_HI) || (s == R_HI);
  endfunction

endpackage

// File: rtl/sw_phase_timer.sv
// Loadable down-counter shared by every timed phase; done is high while the count sits at zero.
module sw_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sw_host_driver.sv
// Host driver that walks the picoMips SW8 handshake for one (x,y) pair and returns the LED results.
// Optional build macro SW_HOST_LED_STABLE_EN: Y_LO/R_HI wait for led_i to settle before sampling.
//
// state | meaning
// IDLE  | core running, waiting for operands (in_ready=1)
// X_HI  | x on data, SW8=1
// X_LO  | x on data, SW8=0
// Y_HI  | y on data, SW8=1
// Y_LO  | y on data, SW8=0, x2 sampled on exit
// R_HI  | data=0, SW8=1, y2 sampled on exit
// R_LO  | data=0, SW8=0, core back at its wait-for-SW8 point
// RES   | result held until res_ready
module sw_host_driver
  import sw_host_pkg::*;
#(
  parameter int HI_CYC     = 32,
  parameter int LO_CYC     = 32,
  parameter int STABLE_CYC = 8
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SW_DATA_W-1:0]        in_x,
  input  logic [SW_DATA_W-1:0]        in_y,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [SW_DATA_W-1:0] res_x2,
  output logic signed [SW_DATA_W-1:0] res_y2,
  output logic [SW_RUN_BIT:0]         sw_o,
  input  logic [SW_DATA_W-1:0]        led_i,
  output logic                        busy
);

  localparam int MAX_CYC = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);

  if (HI_CYC < 32 || LO_CYC < 32 || STABLE_CYC < 1) begin : g_bad_param
    $error("sw_host_driver: HI_CYC/LO_CYC must be >= 32 and STABLE_CYC >= 1");
  end

  state_t               state, state_nxt;
  logic [SW_DATA_W-1:0] x_q, y_q, x_nxt, y_nxt, data_nxt;
  logic                 accept, advance, sample_ok;
  logic                 tmr_load, tmr_done;
  logic [CNT_W-1:0]     tmr_val;

  sw_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef SW_HOST_LED_STABLE_EN
  localparam int STAB_W = $clog2(STABLE_CYC + 1);

  // run_q: length of the current led_i run as of the previous cycle, 0 right after state entry.
  logic [STAB_W-1:0]    run_q, run_now;
  logic [SW_DATA_W-1:0] led_prev;

  always_comb begin
    if (run_q == '0 || led_i != led_prev) begin
      run_now = STAB_W'(1);
    end else if (run_q == STAB_W'(STABLE_CYC)) begin
      run_now = run_q;
    end else begin
      run_now = run_q + STAB_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      run_q    <= '0;
      led_prev <= '0;
    end else begin
      led_prev <= led_i;
      run_q    <= tmr_load ? '0 : run_now;
    end
  end

  assign sample_ok = ((state != Y_LO) && (state != R_HI)) ||
                     (run_now == STAB_W'(STABLE_CYC));
`else
  assign sample_ok = 1'b1;
`endif

  always_comb begin
    accept    = (state == IDLE) && in_valid && in_ready;
    advance   = phase_timed(state) && tmr_done && sample_ok;
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = X_HI;
      X_HI:    if (advance)   state_nxt = X_LO;
      X_LO:    if (advance)   state_nxt = Y_HI;
      Y_HI:    if (advance)   state_nxt = Y_LO;
      Y_LO:    if (advance)   state_nxt = R_HI;
      R_HI:    if (advance)   state_nxt = R_LO;
      R_LO:    if (advance)   state_nxt = RES;
      RES:     if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase

    x_nxt = accept ? in_x : x_q;
    y_nxt = accept ? in_y : y_q;
    case (state_nxt)
      X_HI, X_LO: data_nxt = x_nxt;
      Y_HI, Y_LO: data_nxt = y_nxt;
      default:    data_nxt = '0;
    endcase

    // Reload on every entry into a timed phase, so the count never has to wrap.
    tmr_load = (state_nxt != state) && phase_timed(state_nxt);
    tmr_val  = phase_hi(state_nxt) ? CNT_W'(HI_CYC - 1) : CNT_W'(LO_CYC - 1);
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      res_x2    <= '0;
      res_y2    <= '0;
      sw_o      <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      if (state == Y_LO && advance) res_x2 <= $signed(led_i);
      if (state == R_HI && advance) res_y2 <= $signed(led_i);
      sw_o      <= {1'b1, phase_hi(state_nxt), data_nxt};
      in_ready  <= (state_nxt == IDLE);
      res_valid <= (state_nxt == RES);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_sw_host_driver.sv
// Self-checking bench for sw_host_driver with a behavioural picoMips core stub on SW/LED.
// Build with SW_HOST_LED_STABLE_EN defined to exercise the LED settling option.
module tb_sw_host_driver;

  localparam int PH  = 32;
  localparam int LAT = 3 * (PH + PH) + 1;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = 8'h00;
  logic [7:0] in_y = 8'h00;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_x2, res_y2;
  logic [9:0] sw_o;
  logic [7:0] led_i = 8'h00;
  logic       busy;

  int checks = 0;
  int errors = 0;

  sw_host_driver dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_x2    (res_x2),
    .res_y2    (res_y2),
    .sw_o      (sw_o),
    .led_i     (led_i),
    .busy      (busy)
  );

  always #5 Clock = ~Clock;

  // Core stub: reads x on the 1st SW8 rise, y on the 2nd; shows x+y during Y_LO and y-x-5 from the 3rd rise.
  logic       glitch_en = 1'b0;
  logic       prev_stb  = 1'b0;
  logic [7:0] core_x = 8'h00, core_y = 8'h00;
  int         hs_rise = 0;
  int         ylo_cyc = 0;

  always @(negedge Clock) begin
    if (!sw_o[9]) begin
      hs_rise  = 0;
      ylo_cyc  = 0;
      prev_stb = 1'b0;
    end else begin
      if (sw_o[8] && !prev_stb) begin
        hs_rise = hs_rise + 1;
        if (hs_rise == 1) core_x = sw_o[7:0];
        else if (hs_rise == 2) core_y = sw_o[7:0];
        else if (hs_rise == 3) led_i = core_y - core_x - 8'd5;
      end
      if (!sw_o[8] && prev_stb && hs_rise == 3) hs_rise = 0;
      if (!sw_o[8] && hs_rise == 2) begin
        ylo_cyc = ylo_cyc + 1;
        led_i = core_x + core_y;
        if (glitch_en && ylo_cyc >= 28 && ylo_cyc <= 32)
          led_i = (ylo_cyc == 32) ? 8'hA5 : (8'(ylo_cyc) ^ 8'h5A);
      end else begin
        ylo_cyc = 0;
      end
      prev_stb = sw_o[8];
    end
  end

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
    return {x + y, y - x - 8'd5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready(input string tag);
    int waited;
    waited = 0;
    while (!in_ready && waited < 400) begin
      @(negedge Clock);
      waited++;
    end
    if (waited >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: in_ready still %0b after %0d cycles", tag, in_ready, waited);
    end
  endtask

  // One full transaction from a negedge: checks the SW waveform, latency, hold behaviour and release.
  task automatic run_txn(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] ex2, input logic [7:0] ey2,
                         input int hold, input string tag);
    logic [9:0] exp_sw;
    int p;
    wait_ready(tag);
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    for (int c = 1; c < LAT; c++) begin
      @(negedge Clock);
      if (c == 1) in_valid = 1'b0;
      p = (c - 1) / PH;
      case (p)
        0:       exp_sw = {2'b11, x};
        1:       exp_sw = {2'b10, x};
        2:       exp_sw = {2'b11, y};
        3:       exp_sw = {2'b10, y};
        4:       exp_sw = 10'h300;
        default: exp_sw = 10'h200;
      endcase
      chk($sformatf("%s_sw_c%0d", tag, c), sw_o, exp_sw);
      if (res_valid) chk($sformatf("%s_early_valid_c%0d", tag, c), res_valid, 1'b0);
    end
    @(negedge Clock);
    chk({tag, "_res_valid"}, res_valid, 1'b1);
    chk({tag, "_res_x2"}, res_x2, ex2);
    chk({tag, "_res_y2"}, res_y2, ey2);
    for (int h = 0; h < hold; h++) begin
      @(negedge Clock);
      chk($sformatf("%s_hold_valid_%0d", tag, h), res_valid, 1'b1);
      chk($sformatf("%s_hold_x2_%0d", tag, h), res_x2, ex2);
      chk($sformatf("%s_hold_y2_%0d", tag, h), res_y2, ey2);
      chk($sformatf("%s_hold_ready_%0d", tag, h), in_ready, 1'b0);
      chk($sformatf("%s_hold_sw_%0d", tag, h), sw_o, 10'h200);
    end
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
    chk({tag, "_post_valid"}, res_valid, 1'b0);
    chk({tag, "_post_ready"}, in_ready, 1'b1);
    chk({tag, "_post_busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] x, y, x2, y2;
    int         hold;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx, ry, glitch_exp;
    logic [15:0] m;
    logic [15:0] exp_q[$];
    int nacc, nres, seen, lat, exp_lat;
    logic chg;

    vecs[0] = '{x: 8'h28, y: 8'h14, x2: 8'h3C, y2: 8'hE7, hold: 50};
    vecs[1] = '{x: 8'h05, y: 8'h07, x2: 8'h0C, y2: 8'hFD, hold: 0};
    vecs[2] = '{x: 8'hFD, y: 8'h09, x2: 8'h06, y2: 8'h07, hold: 3};
    vecs[3] = '{x: 8'h00, y: 8'h00, x2: 8'h00, y2: 8'hFB, hold: 1};
    vecs[4] = '{x: 8'h7F, y: 8'h80, x2: 8'hFF, y2: 8'hFC, hold: 2};

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk($sformatf("rst_sw_%0d", i), sw_o, 10'h000);
      chk($sformatf("rst_in_ready_%0d", i), in_ready, 1'b0);
      chk($sformatf("rst_res_valid_%0d", i), res_valid, 1'b0);
      chk($sformatf("rst_busy_%0d", i), busy, 1'b0);
      chk($sformatf("rst_res_%0d", i), {res_x2, res_y2}, 16'h0000);
    end
    Reset = 1'b0;
    @(negedge Clock);
    chk("rel_sw", sw_o, 10'h200);
    chk("rel_in_ready", in_ready, 1'b1);

    // Directed table, including the 50-cycle result hold.
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].x, vecs[i].y, vecs[i].x2, vecs[i].y2, vecs[i].hold, $sformatf("vec%0d", i));
    end
    chk("vec0_signed_y2", 32'($signed(vecs[0].y2)), 32'(-25));

    // Reset in the 10th cycle of Y_HI aborts the transaction.
    wait_ready("abort");
    in_x = 8'h33;
    in_y = 8'h44;
    in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    repeat (73) @(negedge Clock);
    chk("abort_pre_sw", sw_o, 10'h344);
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_sw", sw_o, 10'h000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_res_valid", res_valid, 1'b0);
    Reset = 1'b0;
    seen = 0;
    repeat (250) begin
      @(negedge Clock);
      if (res_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    run_txn(8'h21, 8'h02, 8'h23, 8'hDC, 2, "after_abort");

    // in_valid held high across two back-to-back transactions.
    res_ready = 1'b1;
    in_x = 8'h05;
    in_y = 8'h07;
    in_valid = 1'b1;
    nacc = 0;
    nres = 0;
    chg = 1'b0;
    for (int cyc = 0; cyc < 900 && nres < 2; cyc++) begin
      if (chg) begin
        if (nacc == 1) begin
          in_x = 8'hFD;
          in_y = 8'h09;
        end else begin
          in_valid = 1'b0;
        end
        chg = 1'b0;
      end
      if (in_ready && busy) chk("b2b_ready_while_busy", in_ready, 1'b0);
      if (res_valid) begin
        nres++;
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected_result", {res_x2, res_y2}, 16'hxxxx);
        end else begin
          m = exp_q.pop_front();
          chk($sformatf("b2b_res_%0d", nres), {res_x2, res_y2}, m);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_x, in_y));
        nacc++;
        chg = 1'b1;
      end
      @(negedge Clock);
    end
    in_valid = 1'b0;
    res_ready = 1'b0;
    chk("b2b_accepts", nacc, 2);
    chk("b2b_results", nres, 2);

    // Random operands and random result back-pressure against the model.
    for (int i = 0; i < 6; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      m = model(rx, ry);
      run_txn(rx, ry, m[15:8], m[7:0], int'($urandom_range(0, 5)), $sformatf("rnd%0d", i));
    end

    // LED glitch on the last five cycles of Y_LO.
`ifdef SW_HOST_LED_STABLE_EN
    glitch_exp = 8'h30;
    exp_lat = LAT + 8;
`else
    glitch_exp = 8'hA5;
    exp_lat = LAT;
`endif
    glitch_en = 1'b1;
    wait_ready("glitch");
    in_x = 8'h10;
    in_y = 8'h20;
    in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 400) begin
      @(negedge Clock);
      lat++;
    end
    chk("glitch_latency", lat, exp_lat);
    chk("glitch_x2", res_x2, glitch_exp);
    chk("glitch_y2", res_y2, 8'h0B);
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
    glitch_en = 1'b0;
    chk("glitch_post_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
